note_follower: RTL and testbench

- Consumes the debounced one-hot note from the microphone pitch detector and tracks the player's progress through a fixed song.
- Detects each new note onset and compares it with the expected song note; on a match it advances the song pointer, otherwise it records a miss.
- Its index, expected-note and score outputs feed the staff renderer and the seven-segment/LED status logic.

---
 rtl/note_pkg.sv | 39 +++
 rtl/note_onset_qualifier.sv | 79 +++++++
 rtl/note_follower.sv | 65 ++++++
 tb/tb_note_follower.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared note encodings, song melody and follower state type.
// Used by the note follower and the staff renderer.
package note_pkg;

  localparam int unsigned w_note      = 12;
  localparam int unsigned song_len    = 62;
  localparam int unsigned hold_cycles = 16;
  localparam int unsigned w_idx       = $clog2(song_len);
  localparam int unsigned w_cnt       = 8;

  // One-hot note codes, bit 11 = C down to bit 0 = B
  localparam logic [w_note-1:0] note_c  = 12'h800;
  localparam logic [w_note-1:0] note_d  = 12'h200;
  localparam logic [w_note-1:0] note_e  = 12'h080;
  localparam logic [w_note-1:0] note_f  = 12'h040;
  localparam logic [w_note-1:0] note_g  = 12'h010;
  localparam logic [w_note-1:0] note_a  = 12'h004;
  localparam logic [w_note-1:0] note_b  = 12'h001;
  localparam logic [w_note-1:0] no_note = 12'h000;

  typedef enum logic [1:0] {
    WAIT_RELEASE = 2'd0,
    ARMED        = 2'd1,
    QUALIFY      = 2'd2,
    DONE         = 2'd3
  } state_t;

  localparam logic [w_note-1:0] song_table [song_len] = '{
    note_e, note_g, note_a, note_g, note_e, note_d, note_c, note_d,
    note_e, note_e, note_d, note_c, note_d, note_e, note_g, note_a,
    note_g, note_e, note_d, note_c, note_c, note_d, note_e, note_f,
    note_g, note_a, note_b, note_a, note_g, note_f, note_e, note_d,
    note_c, note_e, note_g, note_e, note_d, note_f, note_a, note_f,
    note_e, note_g, note_b, note_g, note_f, note_a, note_c, note_a,
    note_g, note_f, note_e, note_d, note_e, note_f, note_g, note_a,
    note_g, note_e, note_d, note_c, note_d, note_c
  };

endpackage

// File: rtl/note_onset_qualifier.sv
// Turns a debounced one-hot note stream into single onset strobes once a note
// has been stable for hold_cycles; a new onset requires silence in between.
module note_onset_qualifier
  import note_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              hold,
  input  logic [w_note-1:0] note_in,
  output logic              onset_valid,
  output logic [w_note-1:0] onset_note
);

  localparam int unsigned w_q = $clog2(hold_cycles + 1);

  state_t            state;
  logic [w_note-1:0] cand;
  logic [w_q-1:0]    qcnt;
  logic              valid_c;
  logic              silent_c;

  // Multi-bit codes are neither valid nor silent
  assign silent_c = (note_in == no_note);
  assign valid_c  = !silent_c && ((note_in & (note_in - w_note'(1))) == no_note);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_RELEASE;
      cand        <= no_note;
      qcnt        <= '0;
      onset_valid <= 1'b0;
      onset_note  <= no_note;
    end else begin
      onset_valid <= 1'b0;
      if (clear) begin
        state <= WAIT_RELEASE;
        qcnt  <= '0;
      end else begin
        case (state)
          WAIT_RELEASE: begin
            if (hold)          state <= DONE;
            else if (silent_c) state <= ARMED;
          end
          ARMED: begin
            if (hold) begin
              state <= DONE;
            end else if (valid_c) begin
              cand  <= note_in;
              qcnt  <= w_q'(1);
              state <= QUALIFY;
            end
          end
          QUALIFY: begin
            if (note_in == cand) begin
              if (qcnt == w_q'(hold_cycles - 1)) begin
                onset_valid <= 1'b1;
                onset_note  <= cand;
                qcnt        <= '0;
                state       <= WAIT_RELEASE;
              end else begin
                qcnt <= qcnt + w_q'(1);
              end
            end else if (valid_c) begin
              cand <= note_in;
              qcnt <= w_q'(1);
            end else begin
              qcnt  <= '0;
              state <= ARMED;
            end
          end
          DONE: state <= DONE;
          default: state <= WAIT_RELEASE;
        endcase
      end
    end
  end

endmodule

// File: rtl/note_follower.sv
// Follows the player through the song: judges each qualified onset against the
// expected note, advances the pointer on hits and keeps saturating scores.
module note_follower
  import note_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [w_note-1:0] note_in,
  input  logic              start,
  output logic [w_idx-1:0]  note_idx,
  output logic [w_note-1:0] expected_note,
  output logic              hit_pulse,
  output logic              miss_pulse,
  output logic [w_cnt-1:0]  hit_count,
  output logic [w_cnt-1:0]  miss_count,
  output logic              done
);

  logic              onset_valid;
  logic [w_note-1:0] onset_note;

  note_onset_qualifier u_qual (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (start),
    .hold        (done),
    .note_in     (note_in),
    .onset_valid (onset_valid),
    .onset_note  (onset_note)
  );

  assign expected_note = song_table[note_idx];

  // start outranks a judgement arriving in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_idx   <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      done       <= 1'b0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (start) begin
        note_idx   <= '0;
        hit_count  <= '0;
        miss_count <= '0;
        done       <= 1'b0;
      end else if (onset_valid && !done) begin
        if (onset_note == expected_note) begin
          hit_pulse <= 1'b1;
          if (hit_count != '1) hit_count <= hit_count + w_cnt'(1);
          if (note_idx == w_idx'(song_len - 1)) done <= 1'b1;
          else note_idx <= note_idx + w_idx'(1);
        end else begin
          miss_pulse <= 1'b1;
          if (miss_count != '1) miss_count <= miss_count + w_cnt'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_note_follower.sv
// Scoreboard bench for note_follower: stimulus queues expected judgements,
// a monitor checks every pulse the DUT produces against them.
module tb_note_follower;
  import note_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [w_note-1:0] note_in;
  logic              start;
  logic [w_idx-1:0]  note_idx;
  logic [w_note-1:0] expected_note;
  logic              hit_pulse;
  logic              miss_pulse;
  logic [w_cnt-1:0]  hit_count;
  logic [w_cnt-1:0]  miss_count;
  logic              done;

  note_follower dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .note_in       (note_in),
    .start         (start),
    .note_idx      (note_idx),
    .expected_note (expected_note),
    .hit_pulse     (hit_pulse),
    .miss_pulse    (miss_pulse),
    .hit_count     (hit_count),
    .miss_count    (miss_count),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit hit;
    int idx;
    int hc;
    int mc;
    bit dn;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;
  int m_idx, m_hit, m_miss;
  bit m_done;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && (hit_pulse || miss_pulse)) begin
      check("pulse_exclusive", int'(hit_pulse && miss_pulse), 0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: hit=%0b miss=%0b idx=%0d", hit_pulse, miss_pulse, note_idx);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_hit_pulse", int'(hit_pulse), int'(e.hit));
        check("sb_miss_pulse", int'(miss_pulse), int'(!e.hit));
        check("sb_note_idx", int'(note_idx), e.idx);
        check("sb_hit_count", int'(hit_count), e.hc);
        check("sb_miss_count", int'(miss_count), e.mc);
        check("sb_done", int'(done), int'(e.dn));
      end
    end
  end

  task automatic model_clear();
    m_idx = 0; m_hit = 0; m_miss = 0; m_done = 1'b0;
  endtask

  task automatic expect_judge(input bit hit);
    exp_t e;
    if (hit) begin
      if (m_hit < 255) m_hit++;
      if (m_idx == 61) m_done = 1'b1;
      else m_idx++;
    end else begin
      if (m_miss < 255) m_miss++;
    end
    e.hit = hit; e.idx = m_idx; e.hc = m_hit; e.mc = m_miss; e.dn = m_done;
    q.push_back(e);
  endtask

  // Present n across 'cycles' rising edges; returns 1 time unit after the last
  task automatic drive(input logic [w_note-1:0] n, input int cycles);
    note_in = n;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic play(input logic [w_note-1:0] n, input bit hit);
    drive(12'h000, 2);
    expect_judge(hit);
    drive(n, 16);
    drive(12'h000, 3);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    note_in = 12'h000;
    start   = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_note_idx", int'(note_idx), 0);
    check("rst_hit_count", int'(hit_count), 0);
    check("rst_miss_count", int'(miss_count), 0);
    check("rst_done", int'(done), 0);
    check("rst_expected", int'(expected_note), 'h080);
    check("rst_state", int'(dut.u_qual.state), int'(WAIT_RELEASE));
    rst_n = 1'b1;

    // First note E: pulse exactly 17 edges after the first stable one
    drive(12'h000, 2);
    expect_judge(1'b1);
    drive(12'h080, 16);
    check("latency_no_early_pulse", int'(hit_pulse), 0);
    drive(12'h000, 1);
    check("latency_pulse_at_17", int'(hit_pulse), 1);
    drive(12'h000, 2);
    check("e_note_idx", int'(note_idx), 1);
    check("e_expected_g", int'(expected_note), 'h010);
    check("e_hit_count", int'(hit_count), 1);

    // Wrong note D held long: one miss only
    drive(12'h000, 2);
    expect_judge(1'b0);
    drive(12'h200, 116);
    drive(12'h000, 3);
    check("d_miss_count", int'(miss_count), 1);
    check("d_note_idx", int'(note_idx), 1);

    // Short E burst is dropped; second full burst judged once (miss vs G)
    drive(12'h000, 2);
    expect_judge(1'b0);
    drive(12'h080, 10);
    drive(12'h000, 1);
    drive(12'h080, 16);
    drive(12'h000, 3);
    check("burst_miss_count", int'(miss_count), 2);

    // Direct change to another valid note after a judgement does not re-arm
    drive(12'h000, 2);
    expect_judge(1'b0);
    drive(12'h200, 16);
    drive(12'h010, 20);
    drive(12'h000, 3);
    check("norearm_miss_count", int'(miss_count), 3);
    check("norearm_hit_count", int'(hit_count), 1);

    // Switching notes mid-qualify re-latches the candidate
    drive(12'h000, 2);
    drive(12'h200, 5);
    expect_judge(1'b1);
    drive(12'h010, 16);
    drive(12'h000, 3);
    check("relatch_note_idx", int'(note_idx), 2);
    check("relatch_expected_a", int'(expected_note), 'h004);

    // Multi-bit code: no judgement, stays armed
    drive(12'h000, 2);
    drive(12'h090, 50);
    check("multibit_state", int'(dut.u_qual.state), int'(ARMED));
    check("multibit_counts", int'(hit_count) + int'(miss_count), 5);

    // Full song from a fresh start
    pulse_start();
    model_clear();
    check("start_note_idx", int'(note_idx), 0);
    check("start_hit_count", int'(hit_count), 0);
    check("start_miss_count", int'(miss_count), 0);
    for (int i = 0; i < 62; i++) play(song_table[i], 1'b1);
    check("song_done", int'(done), 1);
    check("song_hit_count", int'(hit_count), 62);
    check("song_note_idx", int'(note_idx), 61);
    check("song_miss_count", int'(miss_count), 0);
    drive(12'h000, 2);
    drive(12'h800, 20);
    drive(12'h000, 2);
    drive(12'h080, 20);
    drive(12'h000, 3);
    check("after_done_state", int'(dut.u_qual.state), int'(DONE));
    check("after_done_hits", int'(hit_count), 62);

    // start coincides with the cycle the judgement would register
    pulse_start();
    model_clear();
    drive(12'h000, 2);
    drive(12'h080, 16);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("collide_hit_pulse", int'(hit_pulse), 0);
    check("collide_note_idx", int'(note_idx), 0);
    check("collide_hit_count", int'(hit_count), 0);
    check("collide_done", int'(done), 0);
    drive(12'h080, 5);
    drive(12'h000, 3);

    // 300 wrong notes saturate the miss counter
    for (int i = 0; i < 300; i++) play(12'h200, 1'b0);
    check("sat_miss_count", int'(miss_count), 255);
    check("sat_note_idx", int'(note_idx), 0);

    // Asynchronous reset in the middle of qualifying a note
    drive(12'h000, 2);
    drive(12'h080, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_miss_count", int'(miss_count), 0);
    check("arst_hit_count", int'(hit_count), 0);
    check("arst_note_idx", int'(note_idx), 0);
    check("arst_pulses", int'(hit_pulse) + int'(miss_pulse), 0);
    check("arst_state", int'(dut.u_qual.state), int'(WAIT_RELEASE));
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(12'h080, 25);
    drive(12'h000, 3);
    check("arst_no_late_pulse", int'(hit_count) + int'(miss_count), 0);

    check("sb_pending", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
